level_digit_rom: RTL and testbench
==================================

Name: level_digit_rom

Overview:
- Registered glyph ROM. Converts a small unsigned number into a 9-row x 16-pixel bitmap of one decimal digit.
- Used by the line-fall display path to overlay level, score, target and chance digits onto raster lines.
- Four instances run in parallel, one per on-screen digit source.
- Glyphs are drawn in a fixed seven-segment style, so the ROM contents are fully defined by this spec.

Parameters:
- None. Geometry is fixed: 9 rows, 16 columns, 144-bit output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- level_num  input  5  value to render. Narrower sources (e.g. 3-bit level) are zero-extended by the instantiator.
- data  output  144  glyph bitmap.
  - Row r (0 = top) sits at data[143-16r : 128-16r].
  - Within a row, bit 15 is the leftmost pixel; 1 = pixel lit.

Behaviour:
- Reset and latency:
  - While rst_n = 0, data = 0 immediately (asynchronous) and stays 0.
  - After reset release, on every rising clk, data <= glyph(level_num).
  - Latency is one cycle; data is a pure register output.
- No enable and no handshake. level_num is sampled every cycle and may change every cycle.
- Column c (0 = leftmost) maps to row bit 15-c.
- Segment geometry:
  - a: row 0, columns 4..11 (0x0FF0).
  - g: row 4, columns 4..11 (0x0FF0).
  - d: row 8, columns 4..11 (0x0FF0).
  - f: column 4 (0x0800), rows 0..4.
  - b: column 11 (0x0010), rows 0..4.
  - e: column 4 (0x0800), rows 4..8.
  - c: column 11 (0x0010), rows 4..8.
- Each row value is the bitwise OR of all active segments covering that row.
- Digit to active-segment map:
  - 0: a b c d e f
  - 1: b c
  - 2: a b d e g
  - 3: a b c d g
  - 4: b c f g
  - 5: a c d f g
  - 6: a c d e f g
  - 7: a b c
  - 8: a b c d e f g
  - 9: a b c d f g
- Values 10..31 render blank: data = 0 on the next edge. This is not an error case.
- Columns 0..3 and 12..15 are always 0, which leaves spacing between adjacent digits.
- Reset asserted mid-stream clears data asynchronously. The first edge after release loads glyph(level_num).

Decomposition:
- Shared package digit_font_pkg, containing:
  - glyph geometry constants: ROWS=9, COLS=16, GLYPH_W=144;
  - row masks: H_ROW=16'h0FF0, L_COL=16'h0800, R_COL=16'h0010;
  - a 10-entry 7-bit segment table, ordered {a,b,c,d,e,f,g}.
- One natural sub-module, seg_to_rows: combinational, 7 segment bits in, 144-bit glyph out.
- The top block adds the digit decode, the out-of-range blanking and the output register.

Test Plan:
- Reset: hold rst_n = 0 with level_num = 8 and clock running → data = 0. Assert rst_n low mid-run with data nonzero → data = 0 without waiting for a clk edge.
- Digit 8: level_num = 8, one edge → data = {0FF0,0810,0810,0810,0FF0,0810,0810,0810,0FF0}.
- Digits 1 and 0:
  - level_num = 1 → all nine rows = 0010.
  - level_num = 0 → {0FF0, 0810 x7, 0FF0}; row 4 = 0810.
- Latency and back-to-back changes: drive 2, 7, 4 on consecutive cycles → data shows each glyph exactly one edge later.
  - 2 = {0FF0,0010,0010,0010,0FF0,0800,0800,0800,0FF0}
  - 7 = {0FF0, 0010 x8}
  - 4 = {0810,0810,0810,0810,0FF0,0010,0010,0010,0010}
- Out of range: level_num = 10, then 31 → data = 0. Then level_num = 9 → {0FF0,0810,0810,0810,0FF0,0010,0010,0010,0FF0}.
- Sweep: all 32 values vs. the golden segment table; columns 0..3 and 12..15 are 0 in every row for every value.

Source files
------------

// File: rtl/digit_font_pkg.sv
// Seven-segment digit font shared by the glyph ROMs: geometry, row masks and
// the per-digit segment table.
package digit_font_pkg;

  localparam int ROWS    = 9;
  localparam int COLS    = 16;
  localparam int GLYPH_W = ROWS * COLS;

  localparam logic [COLS-1:0] H_ROW = 16'h0FF0;
  localparam logic [COLS-1:0] L_COL = 16'h0800;
  localparam logic [COLS-1:0] R_COL = 16'h0010;

  localparam int NUM_DIGITS = 10;

  // Entry bits are {a,b,c,d,e,f,g}; concatenation lists digit 9 first.
  localparam logic [NUM_DIGITS-1:0][6:0] SEG_TBL = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
    7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] digit_segs(input logic [4:0] v);
    logic [6:0] s;
    s = '0;
    if (v < 5'(NUM_DIGITS)) s = SEG_TBL[v[3:0]];
    return s;
  endfunction

endpackage

// File: rtl/seg_to_rows.sv
// Combinational segment-to-bitmap expansion; one row slice per generate lane.
module seg_to_rows
  import digit_font_pkg::*;
(
  input  logic [6:0]         segs,
  output logic [GLYPH_W-1:0] glyph
);

  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = segs;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic IS_TOP = (r == 0);
    localparam logic IS_MID = (r == 4);
    localparam logic IS_BOT = (r == ROWS - 1);
    localparam logic UPPER  = (r <= 4);
    localparam logic LOWER  = (r >= 4);

    logic [COLS-1:0] row;

    // Row 4 is shared by the upper and lower vertical segments.
    assign row = ({COLS{seg_a & IS_TOP}} & H_ROW)
               | ({COLS{seg_g & IS_MID}} & H_ROW)
               | ({COLS{seg_d & IS_BOT}} & H_ROW)
               | ({COLS{seg_f & UPPER }} & L_COL)
               | ({COLS{seg_b & UPPER }} & R_COL)
               | ({COLS{seg_e & LOWER }} & L_COL)
               | ({COLS{seg_c & LOWER }} & R_COL);

    assign glyph[GLYPH_W-1-COLS*r -: COLS] = row;
  end

endmodule

// File: rtl/level_digit_rom.sv
// Registered digit glyph ROM: level_num -> 9x16 bitmap, one-cycle latency,
// values above 9 render blank.
module level_digit_rom
  import digit_font_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         level_num,
  output logic [GLYPH_W-1:0] data
);

  logic [6:0]         segs;
  logic [GLYPH_W-1:0] glyph;

  assign segs = digit_segs(level_num);

  seg_to_rows u_seg_to_rows (
    .segs  (segs),
    .glyph (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= glyph;
  end

endmodule

// File: tb/tb_level_digit_rom.sv
// Randomized scoreboard bench for level_digit_rom against a pixel-level font model.
module tb_level_digit_rom;

  typedef struct {
    int           v;
    logic [143:0] exp;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [4:0]   level_num;
  logic [143:0] data;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  level_digit_rom dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .level_num (level_num),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel-level model: paint each lit segment's pixels into a 9x16 grid.
  function automatic logic [143:0] model(input int v);
    string        segs;
    bit           pix [9][16];
    logic [143:0] out;
    case (v)
      0: segs = "abcdef";
      1: segs = "bc";
      2: segs = "abdeg";
      3: segs = "abcdg";
      4: segs = "bcfg";
      5: segs = "acdfg";
      6: segs = "acdefg";
      7: segs = "abc";
      8: segs = "abcdefg";
      9: segs = "abcdfg";
      default: segs = "";
    endcase
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 16; c++) pix[r][c] = 1'b0;
    for (int i = 0; i < segs.len(); i++) begin
      case (segs[i])
        "a": for (int c = 4; c <= 11; c++) pix[0][c] = 1'b1;
        "g": for (int c = 4; c <= 11; c++) pix[4][c] = 1'b1;
        "d": for (int c = 4; c <= 11; c++) pix[8][c] = 1'b1;
        "f": for (int r = 0; r <= 4; r++) pix[r][4]  = 1'b1;
        "b": for (int r = 0; r <= 4; r++) pix[r][11] = 1'b1;
        "e": for (int r = 4; r <= 8; r++) pix[r][4]  = 1'b1;
        "c": for (int r = 4; r <= 8; r++) pix[r][11] = 1'b1;
        default: ;
      endcase
    end
    out = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 16; c++)
        out[143 - 16*r - c] = pix[r][c];
    return out;
  endfunction

  function automatic logic [143:0] margin_mask();
    logic [143:0] m;
    m = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 16; c++)
        if (c < 4 || c > 11) m[143 - 16*r - c] = 1'b1;
    return m;
  endfunction

  task automatic check_zero(input string name);
    checks++;
    if (data !== '0) begin
      failures++;
      $display("FAIL %s got=%h exp=0", name, data);
    end
  endtask

  // Called at a negedge: value is captured on the following posedge.
  task automatic drive(input int v);
    exp_t e;
    level_num = 5'(v);
    e.v   = v;
    e.exp = model(v);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: the DUT updates every edge, so each posedge retires one entry.
  initial begin
    exp_t e;
    logic [143:0] mm;
    mm = margin_mask();
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data !== e.exp) begin
          failures++;
          $display("FAIL glyph lvl=%0d got=%h exp=%h", e.v, data, e.exp);
        end
        checks++;
        if ((data & mm) !== '0) begin
          failures++;
          $display("FAIL margin lvl=%0d got=%h exp=0", e.v, data & mm);
        end
      end
    end
  end

  initial begin
    int dirs[9] = '{8, 1, 0, 2, 7, 4, 10, 31, 9};

    rst_n     = 1'b0;
    level_num = 5'd8;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_hold");
    end

    rst_n = 1'b1;
    drive(dirs[0]);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      drive(dirs[i]);
    end
    for (int v = 0; v < 32; v++) begin
      @(negedge clk);
      drive(v);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(int'($urandom_range(0, 31)));
    end
    @(negedge clk);
    drive(8);
    drain();

    // Mid-run asynchronous reset, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("reset_over_edge");
    @(negedge clk);
    rst_n = 1'b1;
    drive(3);
    @(negedge clk);
    drive(6);
    @(negedge clk);
    drive(5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
